control_fsm: RTL and testbench
==============================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have no parameters.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 opcode, funct3, funct7b5  in  7/3/1  fields of the latched instruction register.
REQ-005 zero, lt  in  1/1  ALU zero flag; ALU_result[0] of the current cycle.
REQ-006 mem_ready  in  1  memory accepted/completed the current mem_req.
REQ-007 mem_req, mem_write, adr_src  out  1/1/1  memory request, write enable, address select (0=PC, 1=ALU_out).
REQ-008 IR_write, PC_write, reg_write  out  1 each  register strobes.
REQ-009 ALU_src1_sel  out  2  0=PC, 1=PC_old, 2=rs1v; ALU_src2_sel  out  2  0=rs2v, 1=imm_ext, 2=constant 4.
REQ-010 ALU_ctrl  out  alu_ctrl_t  ALU operation; result_sel  out  2  0=ALU_out reg, 1=mem data, 2=live ALU_result.
REQ-011 illegal_instr  out  1  trap indicator (see Configuration).

Function
REQ-012 Multicycle FSM; states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LINK, LUI, AUIPC, TRAP.
REQ-013 Unlisted selects/ALU_ctrl are don't-care; unlisted strobes are 0.
REQ-014 FETCH: mem_req=1, adr_src=0, src1=0, src2=2, ADD, result_sel=2; IR_write=PC_write=mem_ready; stay in FETCH while mem_ready=0, else DECODE.
REQ-015 DECODE: src1=1, src2=1, ADD (branch/jump target into ALU_out); next by opcode: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->LUI, 0010111->AUIPC, other->illegal path.
REQ-016 MEMADR: src1=2, src2=1, ADD; ->MEMREAD if opcode[5]=0 else MEMWRITE.
REQ-017 MEMREAD: mem_req=1, adr_src=1; ->MEMWB on mem_ready, else hold. MEMWB: result_sel=1, reg_write=1; ->FETCH.
REQ-018 MEMWRITE: mem_req=mem_write=1, adr_src=1; held until mem_ready, then FETCH.
REQ-019 EXECR: src1=2, src2=0; EXECI: src1=2, src2=1; both ->ALUWB.
REQ-020 funct3 decode: 000 ADD (SUB if EXECR and funct7b5=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7b5=1), 110 OR, 111 AND.
REQ-021 ALUWB: result_sel=0, reg_write=1; ->FETCH.
REQ-022 BRANCH: src1=2, src2=0; funct3 000/001 SUB, taken=zero/!zero; 100/101 SLT, 110/111 SLTU, taken=lt/!lt; PC_write=taken, result_sel=0 (combinational, same cycle); funct3 010/011 illegal; ->FETCH.
REQ-023 JAL: result_sel=0, PC_write=1; ->LINK. JALR: src1=2, src2=1, ADD, result_sel=2, PC_write=1; ->LINK.
REQ-024 LINK: src1=1, src2=2, ADD, result_sel=2, reg_write=1; ->FETCH.
REQ-025 LUI: src2=1, SRC2; AUIPC: src1=1, src2=1, ADD; both ->ALUWB.
REQ-026 Exactly one transition per clock; no state skipped; mem_ready ignored outside FETCH/MEMREAD/MEMWRITE.

Reset
REQ-027 rst=1 forces FETCH immediately, from any state including mid-MEMREAD/MEMWRITE stall.
REQ-028 While rst=1 all strobes (mem_req, mem_write, IR_write, PC_write, reg_write) and illegal_instr SHALL be 0; selects show FETCH values.
REQ-029 First FETCH cycle follows the first clk edge after rst deasserts.

Configuration
REQ-030 Macro ILLEGAL_TRAP_EN: defined -> illegal opcode/branch funct3 enters TRAP; TRAP holds until reset, illegal_instr=1, all strobes 0.
REQ-031 Undefined -> illegal path returns to FETCH as a NOP (no strobes); TRAP state absent; illegal_instr tied 0.

Verification
REQ-032 ADD x1 (opcode 0110011, funct3 000, funct7b5 0), mem_ready=1 -> FETCH,DECODE,EXECR(ADD),ALUWB(reg_write),FETCH: 4 cycles.
REQ-033 FETCH with mem_ready=0 for 3 cycles then 1 -> IR_write/PC_write 0 for 3 cycles, 1 on the 4th, then DECODE.
REQ-034 BEQ (funct3 000): zero=1 -> PC_write=1 in BRANCH; zero=0 -> PC_write=0; BLTU, lt=1 -> ALU_ctrl=SLTU, PC_write=1.
REQ-035 LW then SW, mem_ready low 2 cycles in MEMREAD/MEMWRITE -> states held, mem_write held 1 in MEMWRITE until ready; MEMWB reg_write=1, result_sel=1.
REQ-036 JALR -> JALR cycle PC_write=1 result_sel=2, LINK cycle reg_write=1 src1=1 src2=2.
REQ-037 rst pulse during MEMREAD stall -> FETCH immediately, strobes 0; opcode 0000000 with ILLEGAL_TRAP_EN -> TRAP, illegal_instr=1 until reset.

Source files
------------

// File: rtl/control_fsm.sv
// ---------------------------------------------------------------------------
// control_fsm -- multicycle RV32I-style control unit.
//
// Sequences one instruction through FETCH -> DECODE -> execute states and
// drives the datapath selects, ALU operation and register/memory strobes.
// State is held in a single register. The outputs are decoded from that
// register. A few strobes also follow live inputs in the same cycle:
// IR_write/PC_write follow mem_ready in FETCH, and PC_write follows the
// branch condition in BRANCH.
//
// Optional feature (macro ILLEGAL_TRAP_EN):
//   defined   : illegal opcode / branch funct3 enters TRAP, which holds
//               until reset with illegal_instr=1 and all strobes 0.
//   undefined : the illegal path returns to FETCH as a NOP and
//               illegal_instr is tied 0.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   i_opcode/i_funct3/i_funct7b5  fields of the latched instruction
//   i_zero, i_lt          ALU zero flag, ALU_result[0] of this cycle
//   i_mem_ready           memory accepted/completed the current request
//   o_mem_req/o_mem_write/o_adr_src  memory request, write, address select
//   o_IR_write/o_PC_write/o_reg_write  register strobes
//   o_ALU_src1_sel        0=PC, 1=PC_old, 2=rs1v
//   o_ALU_src2_sel        0=rs2v, 1=imm_ext, 2=constant 4
//   o_ALU_ctrl            ALU operation
//   o_result_sel          0=ALU_out reg, 1=mem data, 2=live ALU_result
//   o_illegal_instr       trap indicator
// ---------------------------------------------------------------------------
package control_fsm_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_SRC2 = 4'd10
    } alu_ctrl_t;
endpackage

module control_fsm
    import control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    input  logic       i_lt,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_write,
    output logic       o_adr_src,
    output logic       o_IR_write,
    output logic       o_PC_write,
    output logic       o_reg_write,
    output logic [1:0] o_ALU_src1_sel,
    output logic [1:0] o_ALU_src2_sel,
    output alu_ctrl_t  o_ALU_ctrl,
    output logic [1:0] o_result_sel,
    output logic       o_illegal_instr
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14
`ifdef ILLEGAL_TRAP_EN
        ,
        S_TRAP     = 4'd15
`endif
    } state_t;

`ifdef ILLEGAL_TRAP_EN
    localparam state_t S_ILLEGAL = S_TRAP;
`else
    localparam state_t S_ILLEGAL = S_FETCH;
`endif

    state_t r_state;

    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_adr_src;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic [1:0] w_src1;
    logic [1:0] w_src2;
    alu_ctrl_t  w_alu;
    logic [1:0] w_res;
`ifdef ILLEGAL_TRAP_EN
    logic       w_illegal;
`endif

    // ALU operation for register (is_r=1) and immediate arithmetic;
    // SUB exists only in the register form, SRA in both.
    function automatic alu_ctrl_t f_alu_op(input logic [2:0] f3,
                                           input logic       f7b5,
                                           input logic       is_r);
        alu_ctrl_t op;
        case (f3)
            3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Comparison used by each branch type.
    function automatic alu_ctrl_t f_branch_op(input logic [2:0] f3);
        alu_ctrl_t op;
        case (f3)
            3'b000, 3'b001: op = ALU_SUB;
            3'b100, 3'b101: op = ALU_SLT;
            3'b110, 3'b111: op = ALU_SLTU;
            default:        op = ALU_SUB;
        endcase
        return op;
    endfunction

    // Branch condition; the illegal funct3 codes never take the branch.
    function automatic logic f_branch_taken(input logic [2:0] f3,
                                            input logic       z,
                                            input logic       l);
        logic t;
        case (f3)
            3'b000:         t = z;
            3'b001:         t = ~z;
            3'b100, 3'b110: t = l;
            3'b101, 3'b111: t = ~l;
            default:        t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic f_branch_illegal(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

    // State register and transition logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    r_state <= i_mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (i_opcode)
                        7'b0000011, 7'b0100011: r_state <= S_MEMADR;
                        7'b0110011:             r_state <= S_EXECR;
                        7'b0010011:             r_state <= S_EXECI;
                        7'b1100011:             r_state <= S_BRANCH;
                        7'b1101111:             r_state <= S_JAL;
                        7'b1100111:             r_state <= S_JALR;
                        7'b0110111:             r_state <= S_LUI;
                        7'b0010111:             r_state <= S_AUIPC;
                        default:                r_state <= S_ILLEGAL;
                    endcase
                end
                // opcode[5] separates store (1) from load (0)
                S_MEMADR:   r_state <= i_opcode[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  r_state <= i_mem_ready ? S_MEMWB : S_MEMREAD;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: r_state <= i_mem_ready ? S_FETCH : S_MEMWRITE;
                S_EXECR:    r_state <= S_ALUWB;
                S_EXECI:    r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_BRANCH:   r_state <= f_branch_illegal(i_funct3) ? S_ILLEGAL : S_FETCH;
                S_JAL:      r_state <= S_LINK;
                S_JALR:     r_state <= S_LINK;
                S_LINK:     r_state <= S_FETCH;
                S_LUI:      r_state <= S_ALUWB;
                S_AUIPC:    r_state <= S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
                S_TRAP:     r_state <= S_TRAP;
`endif
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Output decode from the current state (plus same-cycle inputs).
    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_write = 1'b0;
        w_adr_src   = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_reg_write = 1'b0;
        w_src1      = 2'd0;
        w_src2      = 2'd0;
        w_alu       = ALU_ADD;
        w_res       = 2'd0;
`ifdef ILLEGAL_TRAP_EN
        w_illegal   = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                w_mem_req  = 1'b1;
                w_adr_src  = 1'b0;
                w_src1     = 2'd0;
                w_src2     = 2'd2;
                w_res      = 2'd2;
                w_ir_write = i_mem_ready;
                w_pc_write = i_mem_ready;
            end
            S_DECODE: begin
                w_src1 = 2'd1;
                w_src2 = 2'd1;
            end
            S_MEMADR: begin
                w_src1 = 2'd2;
                w_src2 = 2'd1;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
            end
            S_MEMWB: begin
                w_res       = 2'd1;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
            end
            S_EXECR: begin
                w_src1 = 2'd2;
                w_src2 = 2'd0;
                w_alu  = f_alu_op(i_funct3, i_funct7b5, 1'b1);
            end
            S_EXECI: begin
                w_src1 = 2'd2;
                w_src2 = 2'd1;
                w_alu  = f_alu_op(i_funct3, i_funct7b5, 1'b0);
            end
            S_ALUWB: begin
                w_res       = 2'd0;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                w_src1     = 2'd2;
                w_src2     = 2'd0;
                w_alu      = f_branch_op(i_funct3);
                w_res      = 2'd0;
                w_pc_write = f_branch_taken(i_funct3, i_zero, i_lt);
            end
            S_JAL: begin
                w_res      = 2'd0;
                w_pc_write = 1'b1;
            end
            S_JALR: begin
                w_src1     = 2'd2;
                w_src2     = 2'd1;
                w_res      = 2'd2;
                w_pc_write = 1'b1;
            end
            S_LINK: begin
                w_src1      = 2'd1;
                w_src2      = 2'd2;
                w_res       = 2'd2;
                w_reg_write = 1'b1;
            end
            S_LUI: begin
                w_src2 = 2'd1;
                w_alu  = ALU_SRC2;
            end
            S_AUIPC: begin
                w_src1 = 2'd1;
                w_src2 = 2'd1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                w_illegal = 1'b1;
            end
`endif
            default: begin
                w_src1 = 2'd0;
            end
        endcase
    end

    // Strobes are forced low while reset is held; selects already show
    // FETCH values because the state register is cleared asynchronously.
    assign o_mem_req      = w_mem_req   & ~rst;
    assign o_mem_write    = w_mem_write & ~rst;
    assign o_IR_write     = w_ir_write  & ~rst;
    assign o_PC_write     = w_pc_write  & ~rst;
    assign o_reg_write    = w_reg_write & ~rst;
    assign o_adr_src      = w_adr_src;
    assign o_ALU_src1_sel = w_src1;
    assign o_ALU_src2_sel = w_src2;
    assign o_ALU_ctrl     = w_alu;
    assign o_result_sel   = w_res;
`ifdef ILLEGAL_TRAP_EN
    assign o_illegal_instr = w_illegal & ~rst;
`else
    assign o_illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;
    import control_fsm_pkg::*;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       lt;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] src1, src2, res_sel;
    alu_ctrl_t  alu;
    logic       illegal;

    int n_checks = 0;
    int n_errors = 0;

    // strobe order: {mem_req, mem_write, IR_write, PC_write, reg_write, illegal}
    logic [5:0] strb;
    assign strb = {mem_req, mem_write, ir_write, pc_write, reg_write, illegal};

    control_fsm dut (
        .clk            (clk),
        .rst            (rst),
        .i_opcode       (opcode),
        .i_funct3       (funct3),
        .i_funct7b5     (funct7b5),
        .i_zero         (zero),
        .i_lt           (lt),
        .i_mem_ready    (mem_ready),
        .o_mem_req      (mem_req),
        .o_mem_write    (mem_write),
        .o_adr_src      (adr_src),
        .o_IR_write     (ir_write),
        .o_PC_write     (pc_write),
        .o_reg_write    (reg_write),
        .o_ALU_src1_sel (src1),
        .o_ALU_src2_sel (src2),
        .o_ALU_ctrl     (alu),
        .o_result_sel   (res_sel),
        .o_illegal_instr(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cs(input string tag, input logic [5:0] e);
        chk(tag, {2'b00, strb}, {2'b00, e});
    endtask
    task automatic c1(input string tag, input logic [1:0] e);
        chk(tag, {6'd0, src1}, {6'd0, e});
    endtask
    task automatic c2(input string tag, input logic [1:0] e);
        chk(tag, {6'd0, src2}, {6'd0, e});
    endtask
    task automatic ca(input string tag, input alu_ctrl_t e);
        chk(tag, {4'd0, alu}, {4'd0, e});
    endtask
    task automatic cr(input string tag, input logic [1:0] e);
        chk(tag, {6'd0, res_sel}, {6'd0, e});
    endtask
    task automatic cadr(input string tag, input logic e);
        chk(tag, {7'd0, adr_src}, {7'd0, e});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inst(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7b5 = f7;
    endtask

    // FETCH with immediate mem_ready, then DECODE; ends at the first execute state
    task automatic fetch_decode(input string tag);
        mem_ready = 1'b1;
        #2;
        cs({tag, "_fetch"}, 6'b101100);
        tick();
        mem_ready = 1'b0;
        #2;
        cs({tag, "_decode_strb"}, 6'b000000);
        c1({tag, "_decode_src1"}, 2'd1);
        c2({tag, "_decode_src2"}, 2'd1);
        ca({tag, "_decode_alu"}, ALU_ADD);
        tick();
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; lt = 1'b0;
        inst(7'd0, 3'd0, 1'b0);
        tick();
        #2;
        // reset: strobes 0 even with mem_ready=1, FETCH selects
        cs("rst_strb", 6'b000000);
        c1("rst_src1", 2'd0);
        c2("rst_src2", 2'd2);
        ca("rst_alu", ALU_ADD);
        cr("rst_res", 2'd2);
        tick();

        // FETCH stall 3 cycles, then ready (ADD)
        rst = 1'b0;
        inst(7'b0110011, 3'b000, 1'b0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            cs("fetch_wait", 6'b100000);
            cadr("fetch_wait_adr", 1'b0);
            tick();
        end
        fetch_decode("add");
        #2;
        c1("add_execr_src1", 2'd2);
        c2("add_execr_src2", 2'd0);
        ca("add_execr_alu", ALU_ADD);
        cs("add_execr_strb", 6'b000000);
        tick();
        #2;
        cs("add_aluwb_strb", 6'b000010);
        cr("add_aluwb_res", 2'd0);
        tick();

        // SUB
        inst(7'b0110011, 3'b000, 1'b1);
        fetch_decode("sub");
        #2; ca("sub_alu", ALU_SUB); tick();
        #2; cs("sub_aluwb", 6'b000010); tick();

        // SRAI
        inst(7'b0010011, 3'b101, 1'b1);
        fetch_decode("srai");
        #2; c1("srai_src1", 2'd2); c2("srai_src2", 2'd1); ca("srai_alu", ALU_SRA); tick();
        #2; cs("srai_aluwb", 6'b000010); tick();

        // ADDI with funct7b5=1 stays ADD
        inst(7'b0010011, 3'b000, 1'b1);
        fetch_decode("addi");
        #2; ca("addi_alu", ALU_ADD); tick();
        #2; cs("addi_aluwb", 6'b000010); tick();

        // BEQ taken, then not taken in the same cycle
        inst(7'b1100011, 3'b000, 1'b0);
        zero = 1'b1;
        fetch_decode("beq");
        #2;
        cs("beq_taken", 6'b000100);
        c1("beq_src1", 2'd2); c2("beq_src2", 2'd0);
        ca("beq_alu", ALU_SUB); cr("beq_res", 2'd0);
        zero = 1'b0;
        #1;
        cs("beq_not_taken", 6'b000000);
        tick();

        // BLTU lt=1 taken
        inst(7'b1100011, 3'b110, 1'b0);
        lt = 1'b1;
        fetch_decode("bltu");
        #2; ca("bltu_alu", ALU_SLTU); cs("bltu_strb", 6'b000100); tick();

        // BGE lt=1 not taken
        inst(7'b1100011, 3'b101, 1'b0);
        fetch_decode("bge");
        #2; ca("bge_alu", ALU_SLT); cs("bge_strb", 6'b000000); tick();
        lt = 1'b0;

        // LW with 2 stall cycles; mem_ready=1 in MEMADR must be ignored
        inst(7'b0000011, 3'b010, 1'b0);
        fetch_decode("lw");
        mem_ready = 1'b1;
        #2; c1("lw_memadr_src1", 2'd2); c2("lw_memadr_src2", 2'd1); ca("lw_memadr_alu", ALU_ADD);
        cs("lw_memadr_strb", 6'b000000);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2; cs("lw_memread_wait", 6'b100000); cadr("lw_memread_adr", 1'b1); tick();
        end
        mem_ready = 1'b1;
        #2; cs("lw_memread_go", 6'b100000); tick();
        mem_ready = 1'b0;
        #2; cs("lw_memwb_strb", 6'b000010); cr("lw_memwb_res", 2'd1); tick();

        // SW with 2 stall cycles
        inst(7'b0100011, 3'b010, 1'b0);
        fetch_decode("sw");
        #2; cs("sw_memadr_strb", 6'b000000); tick();
        for (int i = 0; i < 2; i++) begin
            #2; cs("sw_memwrite_wait", 6'b110000); cadr("sw_memwrite_adr", 1'b1); tick();
        end
        mem_ready = 1'b1;
        #2; cs("sw_memwrite_go", 6'b110000); tick();

        // JALR -> LINK
        inst(7'b1100111, 3'b000, 1'b0);
        fetch_decode("jalr");
        #2; cs("jalr_strb", 6'b000100); c1("jalr_src1", 2'd2); c2("jalr_src2", 2'd1);
        ca("jalr_alu", ALU_ADD); cr("jalr_res", 2'd2); tick();
        #2; cs("link_strb", 6'b000010); c1("link_src1", 2'd1); c2("link_src2", 2'd2);
        ca("link_alu", ALU_ADD); cr("link_res", 2'd2); tick();

        // JAL -> LINK
        inst(7'b1101111, 3'b000, 1'b0);
        fetch_decode("jal");
        #2; cs("jal_strb", 6'b000100); cr("jal_res", 2'd0); tick();
        #2; cs("jal_link_strb", 6'b000010); tick();

        // LUI
        inst(7'b0110111, 3'b000, 1'b0);
        fetch_decode("lui");
        #2; cs("lui_strb", 6'b000000); c2("lui_src2", 2'd1); ca("lui_alu", ALU_SRC2); tick();
        #2; cs("lui_aluwb", 6'b000010); tick();

        // AUIPC
        inst(7'b0010111, 3'b000, 1'b0);
        fetch_decode("auipc");
        #2; c1("auipc_src1", 2'd1); c2("auipc_src2", 2'd1); ca("auipc_alu", ALU_ADD); tick();
        #2; cs("auipc_aluwb", 6'b000010); tick();

        // Illegal branch funct3 010: never writes PC
        inst(7'b1100011, 3'b010, 1'b0);
        zero = 1'b1; lt = 1'b1;
        fetch_decode("bill");
        #2; cs("bill_branch_strb", 6'b000000); tick();
        zero = 1'b0; lt = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        mem_ready = 1'b1;
        #2; cs("bill_trap", 6'b000001); tick();
        rst = 1'b1;
        #2; cs("bill_trap_rst", 6'b000000); tick();
        rst = 1'b0;
`endif

        // Reset during a MEMREAD stall
        inst(7'b0000011, 3'b010, 1'b0);
        fetch_decode("lwrst");
        tick();
        mem_ready = 1'b0;
        #2; cs("lwrst_stall", 6'b100000); tick();
        rst = 1'b1; mem_ready = 1'b1;
        #2;
        cs("lwrst_rst_strb", 6'b000000);
        c1("lwrst_rst_src1", 2'd0); c2("lwrst_rst_src2", 2'd2);
        cr("lwrst_rst_res", 2'd2);
        tick();
        rst = 1'b0;
        inst(7'b0000000, 3'b000, 1'b0);
        #2; cs("lwrst_fetch", 6'b101100); cadr("lwrst_fetch_adr", 1'b0); tick();

        // Illegal opcode 0000000
        mem_ready = 1'b1;
        #2; cs("ill_decode", 6'b000000); tick();
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            #2; cs("ill_trap_hold", 6'b000001); tick();
        end
        rst = 1'b1;
        #2; cs("ill_trap_rst", 6'b000000); tick();
        rst = 1'b0;
        #2; cs("ill_after_rst_fetch", 6'b101100); tick();
`else
        #2; cs("ill_nop_fetch", 6'b101100); tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
